mem_link_arbiter: RTL and testbench

Shares the single serial memory link between the instruction cache and the data cache. It latches level-held cache requests, arbitrates them round-robin, and issues each one to the link controller over a valid/ready request port. It tracks read ownership in issue order and routes returning read data and write completions back to the right cache as one-cycle pulses.

---
 rtl/mem_link_arbiter.sv | 294 +++++++++++++++++++++++++++++
 tb/tb_mem_link_arbiter.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_link_arbiter.sv
// mem_link_arbiter
// Shares the single serial memory link between the I-cache and the D-cache.
// Level-held cache requests are arbitrated round-robin and issued over a
// valid/ready request port. Read ownership is tracked in issue order so
// returning read data goes back to the right cache. Completions are returned
// as one-cycle pulses.
module mem_link_arbiter #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    // instruction cache side
    input  logic                  icache_read,
    input  logic [ADDR_WIDTH-1:0] icache_addr,
    output logic                  icache_valid,
    output logic [DATA_WIDTH-1:0] icache_inst,
    // data cache side
    input  logic [1:0]            dcache_rw_flag,
    input  logic [ADDR_WIDTH-1:0] dcache_addr,
    input  logic [DATA_WIDTH-1:0] dcache_write_data,
    input  logic [3:0]            dcache_write_mask,
    output logic                  dcache_read_valid,
    output logic [DATA_WIDTH-1:0] dcache_read_data,
    output logic                  dcache_write_valid,
    // link controller request port
    output logic                  link_req_valid,
    input  logic                  link_req_ready,
    output logic                  link_req_write,
    output logic [ADDR_WIDTH-1:0] link_req_addr,
    output logic [DATA_WIDTH-1:0] link_req_wdata,
    output logic [3:0]            link_req_mask,
    // link controller responses
    input  logic                  link_rd_valid,
    input  logic [DATA_WIDTH-1:0] link_rd_data,
    input  logic                  link_wr_done,
    output logic                  err_unexpected
);

    // Requester lifecycle. HOLD is the cycle right after the completion
    // pulse; the cache may still be holding its request then, so it must
    // not be treated as a new one.
    typedef enum logic [1:0] {
        REQ_IDLE = 2'd0,
        REQ_WAIT = 2'd1,
        REQ_HOLD = 2'd2
    } req_state_e;

    typedef enum logic {
        ARB_FREE = 1'b0,
        ARB_REQ  = 1'b1
    } arb_state_e;

    localparam logic OWNER_I = 1'b0;
    localparam logic OWNER_D = 1'b1;

    // requester state
    req_state_e i_state_q, i_state_d;
    req_state_e d_state_q, d_state_d;
    logic       d_wr_q, d_wr_d;           // D's outstanding request is a write

    // arbiter and registered request fields
    arb_state_e            arb_state_q, arb_state_d;
    logic                  rr_last_q, rr_last_d;
    logic                  link_owner_q, link_owner_d;
    logic                  link_req_valid_q, link_req_valid_d;
    logic                  link_req_write_q, link_req_write_d;
    logic [ADDR_WIDTH-1:0] link_req_addr_q, link_req_addr_d;
    logic [DATA_WIDTH-1:0] link_req_wdata_q, link_req_wdata_d;
    logic [3:0]            link_req_mask_q, link_req_mask_d;

    // read owner FIFO (2 x 1 bit)
    logic [1:0] fifo_mem_q, fifo_mem_d;
    logic       fifo_wr_ptr_q, fifo_wr_ptr_d;
    logic       fifo_rd_ptr_q, fifo_rd_ptr_d;
    logic [1:0] fifo_cnt_q, fifo_cnt_d;

    // completion outputs
    logic                  icache_valid_q, icache_valid_d;
    logic [DATA_WIDTH-1:0] icache_inst_q, icache_inst_d;
    logic                  dcache_read_valid_q, dcache_read_valid_d;
    logic [DATA_WIDTH-1:0] dcache_read_data_q, dcache_read_data_d;
    logic                  dcache_write_valid_q, dcache_write_valid_d;
    logic                  err_q, err_d;

    // decoded conditions
    logic i_elig, d_elig, d_is_write;
    logic grant_i, grant_d;
    logic link_fire, fifo_push, fifo_pop, rd_owner, wr_ok;

    assign i_elig     = (i_state_q == REQ_IDLE) && icache_read;
    assign d_elig     = (d_state_q == REQ_IDLE) && (dcache_rw_flag != 2'b00);
    // 2'b11 counts as a read, so only 2'b01 is a store
    assign d_is_write = (dcache_rw_flag == 2'b01);

    // D wins when it is the only one asking, or when I was granted last.
    assign grant_d = (arb_state_q == ARB_FREE) && d_elig &&
                     (!i_elig || (rr_last_q == OWNER_I));
    assign grant_i = (arb_state_q == ARB_FREE) && i_elig && !grant_d;

    assign link_fire = link_req_valid_q && link_req_ready;
    assign fifo_push = link_fire && !link_req_write_q;
    assign fifo_pop  = link_rd_valid && (fifo_cnt_q != 2'd0);
    assign rd_owner  = fifo_mem_q[fifo_rd_ptr_q];
    assign wr_ok     = link_wr_done && (d_state_q == REQ_WAIT) && d_wr_q;

    // Arbiter next state: register the winner's fields, hold them until accepted.
    always_comb begin
        arb_state_d      = arb_state_q;
        rr_last_d        = rr_last_q;
        link_owner_d     = link_owner_q;
        link_req_valid_d = link_req_valid_q;
        link_req_write_d = link_req_write_q;
        link_req_addr_d  = link_req_addr_q;
        link_req_wdata_d = link_req_wdata_q;
        link_req_mask_d  = link_req_mask_q;
        case (arb_state_q)
            ARB_FREE: begin
                if (grant_d) begin
                    arb_state_d      = ARB_REQ;
                    rr_last_d        = OWNER_D;
                    link_owner_d     = OWNER_D;
                    link_req_valid_d = 1'b1;
                    link_req_write_d = d_is_write;
                    link_req_addr_d  = dcache_addr;
                    link_req_wdata_d = d_is_write ? dcache_write_data : '0;
                    link_req_mask_d  = d_is_write ? dcache_write_mask : 4'b0000;
                end else if (grant_i) begin
                    arb_state_d      = ARB_REQ;
                    rr_last_d        = OWNER_I;
                    link_owner_d     = OWNER_I;
                    link_req_valid_d = 1'b1;
                    link_req_write_d = 1'b0;
                    link_req_addr_d  = icache_addr;
                    link_req_wdata_d = '0;
                    link_req_mask_d  = 4'b0000;
                end
            end
            ARB_REQ: begin
                if (link_fire) begin
                    link_req_valid_d = 1'b0;
                    arb_state_d      = ARB_FREE;
                end
            end
        endcase
    end

    // Arbiter state and request field registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            arb_state_q      <= ARB_FREE;
            rr_last_q        <= OWNER_D;
            link_owner_q     <= OWNER_I;
            link_req_valid_q <= 1'b0;
            link_req_write_q <= 1'b0;
            link_req_addr_q  <= '0;
            link_req_wdata_q <= '0;
            link_req_mask_q  <= 4'b0000;
        end else begin
            arb_state_q      <= arb_state_d;
            rr_last_q        <= rr_last_d;
            link_owner_q     <= link_owner_d;
            link_req_valid_q <= link_req_valid_d;
            link_req_write_q <= link_req_write_d;
            link_req_addr_q  <= link_req_addr_d;
            link_req_wdata_q <= link_req_wdata_d;
            link_req_mask_q  <= link_req_mask_d;
        end
    end

    // Owner FIFO: accepted reads push their owner, read responses pop it.
    always_comb begin
        fifo_mem_d    = fifo_mem_q;
        fifo_wr_ptr_d = fifo_wr_ptr_q;
        fifo_rd_ptr_d = fifo_rd_ptr_q;
        if (fifo_push) begin
            fifo_mem_d[fifo_wr_ptr_q] = link_owner_q;
            fifo_wr_ptr_d             = ~fifo_wr_ptr_q;
        end
        if (fifo_pop) begin
            fifo_rd_ptr_d = ~fifo_rd_ptr_q;
        end
        fifo_cnt_d = fifo_cnt_q + {1'b0, fifo_push} - {1'b0, fifo_pop};
    end

    // Owner FIFO registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fifo_mem_q    <= 2'b00;
            fifo_wr_ptr_q <= 1'b0;
            fifo_rd_ptr_q <= 1'b0;
            fifo_cnt_q    <= 2'd0;
        end else begin
            fifo_mem_q    <= fifo_mem_d;
            fifo_wr_ptr_q <= fifo_wr_ptr_d;
            fifo_rd_ptr_q <= fifo_rd_ptr_d;
            fifo_cnt_q    <= fifo_cnt_d;
        end
    end

    // Response routing: register data, pulse the owner, flag orphan responses.
    always_comb begin
        icache_valid_d       = 1'b0;
        dcache_read_valid_d  = 1'b0;
        dcache_write_valid_d = wr_ok;
        icache_inst_d        = icache_inst_q;
        dcache_read_data_d   = dcache_read_data_q;
        err_d                = err_q;
        if (fifo_pop) begin
            if (rd_owner == OWNER_D) begin
                dcache_read_valid_d = 1'b1;
                dcache_read_data_d  = link_rd_data;
            end else begin
                icache_valid_d = 1'b1;
                icache_inst_d  = link_rd_data;
            end
        end
        if ((link_rd_valid && !fifo_pop) || (link_wr_done && !wr_ok)) begin
            err_d = 1'b1;
        end
    end

    // Completion and error registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            icache_valid_q       <= 1'b0;
            icache_inst_q        <= '0;
            dcache_read_valid_q  <= 1'b0;
            dcache_read_data_q   <= '0;
            dcache_write_valid_q <= 1'b0;
            err_q                <= 1'b0;
        end else begin
            icache_valid_q       <= icache_valid_d;
            icache_inst_q        <= icache_inst_d;
            dcache_read_valid_q  <= dcache_read_valid_d;
            dcache_read_data_q   <= dcache_read_data_d;
            dcache_write_valid_q <= dcache_write_valid_d;
            err_q                <= err_d;
        end
    end

    // Requester lifecycles. WAIT holds through the pulse cycle, HOLD follows
    // it for one cycle, so a requester is IDLE two cycles after its pulse.
    always_comb begin
        i_state_d = i_state_q;
        d_state_d = d_state_q;
        d_wr_d    = d_wr_q;
        case (i_state_q)
            REQ_IDLE: if (grant_i) i_state_d = REQ_WAIT;
            REQ_WAIT: if (icache_valid_q) i_state_d = REQ_HOLD;
            REQ_HOLD: i_state_d = REQ_IDLE;
            default:  i_state_d = REQ_IDLE;
        endcase
        case (d_state_q)
            REQ_IDLE: if (grant_d) d_state_d = REQ_WAIT;
            REQ_WAIT: if (dcache_read_valid_q || dcache_write_valid_q) d_state_d = REQ_HOLD;
            REQ_HOLD: d_state_d = REQ_IDLE;
            default:  d_state_d = REQ_IDLE;
        endcase
        // the write marker clears on its completion so a repeated
        // wr_done during the pulse cycle is seen as unexpected
        if (grant_d) begin
            d_wr_d = d_is_write;
        end else if (wr_ok) begin
            d_wr_d = 1'b0;
        end
    end

    // Requester state registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            i_state_q <= REQ_IDLE;
            d_state_q <= REQ_IDLE;
            d_wr_q    <= 1'b0;
        end else begin
            i_state_q <= i_state_d;
            d_state_q <= d_state_d;
            d_wr_q    <= d_wr_d;
        end
    end

    assign icache_valid       = icache_valid_q;
    assign icache_inst        = icache_inst_q;
    assign dcache_read_valid  = dcache_read_valid_q;
    assign dcache_read_data   = dcache_read_data_q;
    assign dcache_write_valid = dcache_write_valid_q;
    assign link_req_valid     = link_req_valid_q;
    assign link_req_write     = link_req_write_q;
    assign link_req_addr      = link_req_addr_q;
    assign link_req_wdata     = link_req_wdata_q;
    assign link_req_mask      = link_req_mask_q;
    assign err_unexpected     = err_q;

endmodule

// File: tb/tb_mem_link_arbiter.sv
// Directed bench for mem_link_arbiter: single fetch, contention, store,
// orphan responses, backpressure, round-robin under load, async reset.
module tb_mem_link_arbiter;
    localparam int AW = 32;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          icache_read = 1'b0;
    logic [AW-1:0] icache_addr = '0;
    logic          icache_valid;
    logic [DW-1:0] icache_inst;
    logic [1:0]    dcache_rw_flag = 2'b00;
    logic [AW-1:0] dcache_addr = '0;
    logic [DW-1:0] dcache_write_data = '0;
    logic [3:0]    dcache_write_mask = 4'b0000;
    logic          dcache_read_valid;
    logic [DW-1:0] dcache_read_data;
    logic          dcache_write_valid;
    logic          link_req_valid;
    logic          link_req_ready = 1'b0;
    logic          link_req_write;
    logic [AW-1:0] link_req_addr;
    logic [DW-1:0] link_req_wdata;
    logic [3:0]    link_req_mask;
    logic          link_rd_valid = 1'b0;
    logic [DW-1:0] link_rd_data = '0;
    logic          link_wr_done = 1'b0;
    logic          err_unexpected;

    int n_chk = 0;
    int n_err = 0;
    int cyc   = 0;
    logic [AW-1:0] acc_addr[$];
    int            acc_cyc[$];

    always #5 clk = ~clk;

    mem_link_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk(clk), .rst(rst),
        .icache_read(icache_read), .icache_addr(icache_addr),
        .icache_valid(icache_valid), .icache_inst(icache_inst),
        .dcache_rw_flag(dcache_rw_flag), .dcache_addr(dcache_addr),
        .dcache_write_data(dcache_write_data), .dcache_write_mask(dcache_write_mask),
        .dcache_read_valid(dcache_read_valid), .dcache_read_data(dcache_read_data),
        .dcache_write_valid(dcache_write_valid),
        .link_req_valid(link_req_valid), .link_req_ready(link_req_ready),
        .link_req_write(link_req_write), .link_req_addr(link_req_addr),
        .link_req_wdata(link_req_wdata), .link_req_mask(link_req_mask),
        .link_rd_valid(link_rd_valid), .link_rd_data(link_rd_data),
        .link_wr_done(link_wr_done), .err_unexpected(err_unexpected)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic any_out();
        return |{icache_valid, icache_inst, dcache_read_valid, dcache_read_data,
                 dcache_write_valid, link_req_valid, link_req_write, link_req_addr,
                 link_req_wdata, link_req_mask, err_unexpected};
    endfunction

    // one clock; log any handshake that the coming edge will complete
    task automatic step();
        if (!rst && link_req_valid && link_req_ready) begin
            acc_addr.push_back(link_req_addr);
            acc_cyc.push_back(cyc);
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic idle_inputs();
        icache_read    = 1'b0;
        dcache_rw_flag = 2'b00;
        link_req_ready = 1'b0;
        link_rd_valid  = 1'b0;
        link_wr_done   = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle_inputs();
        step();
        step();
        rst = 1'b0;
        step();
        acc_addr.delete();
        acc_cyc.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        int pend;
        int guard;
        // ---------------- reset state
        step();
        step();
        check("rst_outs", any_out(), 0);
        rst = 1'b0;
        step();
        check("rst_idle", link_req_valid, 0);

        // ---------------- single fetch
        icache_read = 1'b1; icache_addr = 32'h100; link_req_ready = 1'b1;
        check("f_no_comb", link_req_valid, 0);
        step();
        check("f_valid", link_req_valid, 1);
        check("f_addr", link_req_addr, 32'h100);
        check("f_rd", link_req_write, 0);
        step();
        check("f_accepted", link_req_valid, 0);
        repeat (3) step();
        link_rd_valid = 1'b1; link_rd_data = 32'hDEADBEEF;
        step();
        link_rd_valid = 1'b0;
        check("f_pulse", icache_valid, 1);
        check("f_inst", icache_inst, 32'hDEADBEEF);
        check("f_no_dpulse", dcache_read_valid, 0);
        step();                                  // cache still holding request
        check("f_pulse_1cyc", icache_valid, 0);
        step();                                  // HOLD masked it
        icache_read = 1'b0;
        check("f_no_dup_a", link_req_valid, 0);
        step();
        check("f_no_dup_b", link_req_valid, 0);
        check("f_one_issue", acc_addr.size(), 1);
        check("f_inst_kept", icache_inst, 32'hDEADBEEF);
        check("f_err", err_unexpected, 0);

        // ---------------- contention from reset
        do_reset();
        icache_read = 1'b1; icache_addr = 32'h40;
        dcache_rw_flag = 2'b10; dcache_addr = 32'h80; link_req_ready = 1'b1;
        step();
        check("c_first_addr", link_req_addr, 32'h40);
        check("c_first_valid", link_req_valid, 1);
        step();
        check("c_gap", link_req_valid, 0);
        step();
        check("c_second_valid", link_req_valid, 1);
        check("c_second_addr", link_req_addr, 32'h80);
        check("c_second_rd", link_req_write, 0);
        step();
        link_rd_valid = 1'b1; link_rd_data = 32'h11;
        step();
        check("c_ipulse", icache_valid, 1);
        check("c_idata", icache_inst, 32'h11);
        check("c_no_d_yet", dcache_read_valid, 0);
        link_rd_data = 32'h22;
        step();
        link_rd_valid = 1'b0;
        icache_read = 1'b0; dcache_rw_flag = 2'b00;
        check("c_dpulse", dcache_read_valid, 1);
        check("c_ddata", dcache_read_data, 32'h22);
        check("c_i_done", icache_valid, 0);
        step();
        step();
        check("c_quiet", link_req_valid, 0);
        check("c_issues", acc_addr.size(), 2);

        // ---------------- store
        acc_addr.delete(); acc_cyc.delete();
        dcache_rw_flag = 2'b01; dcache_addr = 32'h200;
        dcache_write_data = 32'hCAFEF00D; dcache_write_mask = 4'b0011;
        step();
        check("w_valid", link_req_valid, 1);
        check("w_write", link_req_write, 1);
        check("w_addr", link_req_addr, 32'h200);
        check("w_wdata", link_req_wdata, 32'hCAFEF00D);
        check("w_mask", link_req_mask, 4'b0011);
        step();
        step();
        link_wr_done = 1'b1;
        step();
        link_wr_done = 1'b0;
        check("w_pulse", dcache_write_valid, 1);
        check("w_no_rpulse", dcache_read_valid, 0);
        step();
        dcache_rw_flag = 2'b00;
        check("w_pulse_1cyc", dcache_write_valid, 0);
        check("w_err", err_unexpected, 0);
        step();

        // ---------------- orphan responses (write left FIFO empty)
        link_rd_valid = 1'b1; link_rd_data = 32'h99;
        step();
        link_rd_valid = 1'b0;
        check("e_err", err_unexpected, 1);
        check("e_no_ipulse", icache_valid, 0);
        check("e_no_dpulse", dcache_read_valid, 0);
        link_wr_done = 1'b1;
        step();
        link_wr_done = 1'b0;
        check("e_no_wpulse", dcache_write_valid, 0);
        step();
        check("e_sticky", err_unexpected, 1);

        // ---------------- backpressure
        acc_addr.delete(); acc_cyc.delete();
        link_req_ready = 1'b0; icache_read = 1'b1; icache_addr = 32'h300;
        step();
        for (int k = 0; k < 4; k++) begin
            check("b_valid", link_req_valid, 1);
            check("b_addr", link_req_addr, 32'h300);
            check("b_rd", link_req_write, 0);
            if (k == 3) link_req_ready = 1'b1;
            step();
        end
        check("b_accepted", link_req_valid, 0);
        check("b_one_accept", acc_addr.size(), 1);
        link_rd_valid = 1'b1; link_rd_data = 32'h55;
        step();
        link_rd_valid = 1'b0;
        check("b_ipulse", icache_valid, 1);
        check("b_idata", icache_inst, 32'h55);
        step();
        icache_read = 1'b0;
        step();

        // ---------------- round-robin under continuous load
        do_reset();
        icache_read = 1'b1; icache_addr = 32'h1000;
        dcache_rw_flag = 2'b10; dcache_addr = 32'h2000; link_req_ready = 1'b1;
        pend = 0;
        guard = 0;
        while ((acc_addr.size() < 8 || pend < acc_addr.size()) && guard < 300) begin
            if (acc_addr.size() >= 8) begin
                icache_read = 1'b0; dcache_rw_flag = 2'b00;
            end
            link_rd_valid = 1'b0;
            if (pend < acc_addr.size() && cyc >= acc_cyc[pend] + 2) begin
                link_rd_valid = 1'b1;
                link_rd_data  = acc_addr[pend] + 32'h1;
                pend++;
            end
            step();
            guard++;
            if (icache_valid) check("rr_idata", icache_inst, 32'h1001);
            if (dcache_read_valid) check("rr_ddata", dcache_read_data, 32'h2001);
        end
        link_rd_valid = 1'b0; icache_read = 1'b0; dcache_rw_flag = 2'b00;
        check("rr_done_in_budget", (guard < 300), 1);
        for (int k = 0; k < 8; k++) begin
            logic [AW-1:0] got;
            got = (k < acc_addr.size()) ? acc_addr[k] : '0;
            check("rr_order", got, (k % 2 == 0) ? 32'h1000 : 32'h2000);
        end
        step();
        step();
        check("rr_err", err_unexpected, 0);

        // ---------------- async reset mid-REQ
        link_rd_valid = 1'b1;
        step();
        link_rd_valid = 1'b0;
        check("r_err_set", err_unexpected, 1);
        icache_read = 1'b1; icache_addr = 32'h500; link_req_ready = 1'b0;
        step();
        check("r_in_req", link_req_valid, 1);
        #2;
        rst = 1'b1;
        #1;
        check("r_async_outs", any_out(), 0);
        check("r_err_clr", err_unexpected, 0);
        icache_read = 1'b0;
        step();
        rst = 1'b0;
        step();
        check("r_post_idle", link_req_valid, 0);
        link_rd_valid = 1'b1; link_rd_data = 32'h77;
        step();
        link_rd_valid = 1'b0;
        check("r_late_err", err_unexpected, 1);
        check("r_late_no_pulse", icache_valid, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
